timer_seg_scan: RTL
===================

Name: timer_seg_scan

Overview:
Consumer side of the game countdown timer: takes the BCD minute/ten-second/second digits and drives a 4-digit, common-anode, multiplexed seven-segment display. The digits are snapshotted once per scan frame so a half-updated value is never shown. It flags time-up, and optionally blinks the display while time is up. Sits between the countdown timer and the board's display pins.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (50 MHz -> 1 kHz slot rate, 250 Hz frame rate); legal range >= 2
BLINK_FRAMES, 125, scan frames per blink half-period (0.5 s at defaults); legal range >= 1; used only with blink feature

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
en  input  1  display enable; 0 blanks all anodes, scanning continues
min  input  4  BCD minutes digit
sec1  input  4  BCD seconds tens digit
sec2  input  4  BCD seconds units digit
an  output  4  digit anodes, active-low; bit0 = rightmost
seg  output  7  segments gfedcba, active-low
dp  output  1  decimal point, active-low; used as the minute/second separator
time_up  output  1  registered; 1 while the snapshot equals 0:00

Behaviour:
- Reset (async, rst=0, takes effect immediately, also mid-frame): prescaler=0, sel=0, snapshot={2,0,0}, an=4'b1111, seg=7'b1111111, dp=1, time_up=0, blink counter=0, blink phase=on.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. A tick is a one-cycle pulse while the count equals SCAN_DIV-1.
- sel: 2-bit slot index. Advances on tick, 3 wraps to 0.
- Snapshot: on a tick with sel==3, latch min/sec1/sec2 into the snapshot registers. time_up updates on the same edge: time_up <= (min==0 && sec1==0 && sec2==0).
- Outputs are registered from sel and the snapshot, so they reflect the sel value one cycle late.
- Slot mapping:
  - sel0: an=1110, seg=dec(sec2), dp=1
  - sel1: an=1101, seg=dec(sec1), dp=1
  - sel2: an=1011, seg=dec(min), dp=0
  - sel3: an=1111, seg=1111111, dp=1 (dark slot keeps a 1/4 duty cycle)
- Decoding: dec() maps BCD 0-9 to the standard active-low patterns. Any value 10-15 displays a dash, 7'b0111111.
- Blanking: when en=0, an=1111 and dp=1. seg is don't-care but must be driven to 1111111.
- Snapshot changes only at frame boundaries. Input changes mid-frame are not displayed until the next frame.
- Simultaneous events: reset dominates a tick. A snapshot tick and a blink toggle on the same edge both take effect.

Optional Feature:
TIMER_SEG_BLINK_EN.
- Defined:
  - A frame counter counts snapshot ticks 0..BLINK_FRAMES-1.
  - At wrap, the blink phase toggles.
  - While time_up=1 and phase=off, an is forced to 1111.
  - When time_up goes 0, phase is forced on and the counter is cleared.
- Undefined: no blink logic. The display stays steady at 0:00 when time is up. BLINK_FRAMES is ignored.

Decomposition:
- Package timer_seg_pkg holds:
  - SEG_0..SEG_9, SEG_DASH, SEG_BLANK 7-bit constants
  - AN_OFF constant
  - a 2-bit slot-index typedef with the SLOT_SEC2/SEC1/MIN/DARK values
- One natural sub-module, bcd_to_seg: combinational 4-bit BCD to 7-bit active-low decoder, including the dash for values 10-15.
- timer_seg_scan contains the prescaler, slot FSM, snapshot, and blink logic.

Test Plan:
- SCAN_DIV=4, rst pulse, inputs 2/0/0, en=1:
  - an sequence 1110,1101,1011,1111 repeating, 4 cycles per slot
  - sel2 shows seg=0100100, dp=0; sel0 shows seg=1000000
- Change inputs to 1/5/9 mid-frame: display keeps 2:00 until the sel3 tick, then the next frame shows seg 1111001 / 0010010 / 0010000 on the min/sec1/sec2 slots.
- Inputs 0/0/0: time_up=1 one cycle after the next frame-boundary tick. Inputs back to 0/0/1: time_up=0 after the following boundary.
- Input sec2=4'hC: that slot shows seg=0111111 (dash).
- en=0 for a full frame: an=1111 throughout, while sel keeps advancing (check with en=1 re-assert: the slot resumes in phase).
- Reset asserted mid-slot, and with TIMER_SEG_BLINK_EN, SCAN_DIV=2, BLINK_FRAMES=2, inputs 0/0/0:
  - on reset, outputs go to reset values with no clock edge
  - while time is up, anodes alternate between active for 2 frames and 1111 for 2 frames

Source files
------------

// File: rtl/timer_seg_pkg.sv
// rtl/timer_seg_pkg.sv - shared constants and slot type for the timer seven-segment scanner
// Contents: active-low segment patterns (gfedcba), anode-off value, snapshot reset
// digits and the 2-bit scan slot enumeration.
package timer_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Snapshot value held from reset until the first frame boundary (shows 2:00).
    localparam logic [3:0] SNAP_MIN_RST  = 4'd2;
    localparam logic [3:0] SNAP_SEC1_RST = 4'd0;
    localparam logic [3:0] SNAP_SEC2_RST = 4'd0;

    typedef enum logic [1:0] {
        SLOT_SEC2 = 2'd0,
        SLOT_SEC1 = 2'd1,
        SLOT_MIN  = 2'd2,
        SLOT_DARK = 2'd3
    } slot_e;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to active-low seven-segment decoder
// Ports: bcd [3:0] in  - BCD digit; 10..15 are shown as a dash
//        seg [6:0] out - segments gfedcba, active-low
module bcd_to_seg
    import timer_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/timer_seg_scan.sv
// rtl/timer_seg_scan.sv - 4-digit multiplexed seven-segment driver for the countdown timer
// Optional feature macro: TIMER_SEG_BLINK_EN (blink display while time is up).
// Ports: clk      in      system clock
//        rst      in      asynchronous active-low reset
//        en       in      display enable; 0 blanks anodes while scanning continues
//        min      in [4]  BCD minutes digit
//        sec1     in [4]  BCD seconds tens digit
//        sec2     in [4]  BCD seconds units digit
//        an       out [4] digit anodes, active-low, bit0 = rightmost
//        seg      out [7] segments gfedcba, active-low
//        dp       out     decimal point, active-low (minute/second separator)
//        time_up  out     1 while the frame snapshot equals 0:00
module timer_seg_scan
    import timer_seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] min,
    input  logic [3:0] sec1,
    input  logic [3:0] sec2,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       time_up
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_e            sel_q, sel_d;
    logic [3:0]       snap_min_q, snap_min_d;
    logic [3:0]       snap_sec1_q, snap_sec1_d;
    logic [3:0]       snap_sec2_q, snap_sec2_d;
    logic             time_up_q, time_up_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic             frame_tick;
    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;
    logic             blank_an;

    assign tick       = (cnt_q == CNT_LAST);
    // The last tick of the dark slot closes a frame; the snapshot is taken only here
    // so a frame never mixes digits from two different timer values.
    assign frame_tick = tick && (sel_q == SLOT_DARK);

    always_comb begin
        cur_digit = snap_sec2_q;
        case (sel_q)
            SLOT_SEC1: cur_digit = snap_sec1_q;
            SLOT_MIN:  cur_digit = snap_min_q;
            default:   cur_digit = snap_sec2_q;
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

`ifdef TIMER_SEG_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [BF_W-1:0] bcnt_q, bcnt_d;
    logic            blink_on_q, blink_on_d;

    // The blink cadence is only meaningful while time is up; otherwise it is held
    // in its reset state so the next time-up always starts with the display lit.
    always_comb begin
        bcnt_d     = bcnt_q;
        blink_on_d = blink_on_q;
        if (!time_up_q) begin
            bcnt_d     = '0;
            blink_on_d = 1'b1;
        end else if (frame_tick) begin
            if (bcnt_q == BF_LAST) begin
                bcnt_d     = '0;
                blink_on_d = !blink_on_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt_q     <= '0;
            blink_on_q <= 1'b1;
        end else begin
            bcnt_q     <= bcnt_d;
            blink_on_q <= blink_on_d;
        end
    end

    assign blank_an = time_up_q && !blink_on_q;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_FRAMES > 0);
    assign blank_an         = 1'b0;
`endif

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        sel_d       = tick ? slot_e'(sel_q + 2'd1) : sel_q;
        snap_min_d  = snap_min_q;
        snap_sec1_d = snap_sec1_q;
        snap_sec2_d = snap_sec2_q;
        time_up_d   = time_up_q;
        if (frame_tick) begin
            snap_min_d  = min;
            snap_sec1_d = sec1;
            snap_sec2_d = sec2;
            time_up_d   = (min == 4'd0) && (sec1 == 4'd0) && (sec2 == 4'd0);
        end
    end

    // Display outputs are registered from the current slot, so pins lag sel by one cycle.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (en) begin
            case (sel_q)
                SLOT_SEC2: begin
                    an_d  = 4'b1110;
                    seg_d = cur_seg;
                end
                SLOT_SEC1: begin
                    an_d  = 4'b1101;
                    seg_d = cur_seg;
                end
                SLOT_MIN: begin
                    an_d  = 4'b1011;
                    seg_d = cur_seg;
                    dp_d  = 1'b0;
                end
                default: begin
                    an_d  = AN_OFF;
                    seg_d = SEG_BLANK;
                end
            endcase
            if (blank_an) begin
                an_d = AN_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            sel_q       <= SLOT_SEC2;
            snap_min_q  <= SNAP_MIN_RST;
            snap_sec1_q <= SNAP_SEC1_RST;
            snap_sec2_q <= SNAP_SEC2_RST;
            time_up_q   <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            snap_min_q  <= snap_min_d;
            snap_sec1_q <= snap_sec1_d;
            snap_sec2_q <= snap_sec2_d;
            time_up_q   <= time_up_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign time_up = time_up_q;

endmodule
